// File: rtl/mem_arbiter_if.sv
// Bus bundle joining the I-cache refill path, the DataCache path and MainMemory
// through the arbiter. The arbiter uses the slave view; the environment uses master.
interface mem_arbiter_if;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-way MainMemory arbiter: data side wins ties, but after STARVE_LIMIT data grants
// with an instruction fetch waiting, the fetch is forced through next.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GNT_I = 2'd1;
  localparam logic [1:0] S_GNT_D = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_starve_cnt;
  logic          w_d_req;
  logic          w_starved;

  assign w_d_req   = bus.d_read | bus.d_write;
  assign w_starved = (r_starve_cnt == C_LIMIT);

  // Grants are only decided in IDLE and every completion returns there, so a request
  // still held after its ready pulse never reaches memory as a second access.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_read && (!w_d_req || w_starved)) begin
            r_state <= S_GNT_I;
          end else if (w_d_req) begin
            r_state <= S_GNT_D;
          end
        end
        S_GNT_I: begin
          if (bus.mem_ready) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
          end
        end
        S_GNT_D: begin
          if (bus.mem_ready) begin
            r_state <= S_IDLE;
            if (!bus.i_read) begin
              r_starve_cnt <= '0;
            end else if (!w_starved) begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.i_ready   = 1'b0;
    bus.d_ready   = 1'b0;
    case (r_state)
      S_GNT_I: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = bus.i_addr;
        bus.i_ready  = bus.mem_ready;
      end
      S_GNT_D: begin
        // A simultaneous read+write request is carried out as a write.
        bus.mem_write = bus.d_write;
        bus.mem_read  = bus.d_read & ~bus.d_write;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.d_ready   = bus.mem_ready;
      end
      default: ;
    endcase
  end

  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;
endmodule
